// File: rtl/ddr_ctl1_sequencer_pkg.sv
// Shared opcodes, state encoding and lane helpers for the DdrCtl1 request sequencer.
// Revision: 1.0
`default_nettype none

package ddr_ctl1_sequencer_pkg;

  localparam int INST_W = 12;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LA0 = 4'h1;
  localparam logic [3:0] OP_LA1 = 4'h2;
  localparam logic [3:0] OP_LA2 = 4'h3;
  localparam logic [3:0] OP_LA3 = 4'h4;
  localparam logic [3:0] OP_LD0 = 4'h5;
  localparam logic [3:0] OP_LD1 = 4'h6;
  localparam logic [3:0] OP_LD2 = 4'h7;
  localparam logic [3:0] OP_LD3 = 4'h8;
  localparam logic [3:0] OP_RDP = 4'h9;
  localparam logic [3:0] OP_WRP = 4'hA;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_ADDR      = 3'd1;
  localparam state_t ST_DATA      = 3'd2;
  localparam state_t ST_ISSUE     = 3'd3;
  localparam state_t ST_WAIT_BUSY = 3'd4;
  localparam state_t ST_WAIT_DONE = 3'd5;
  localparam state_t ST_RESP      = 3'd6;

  function automatic logic [3:0] la_op(input logic [1:0] idx);
    case (idx)
      2'd0:    return OP_LA0;
      2'd1:    return OP_LA1;
      2'd2:    return OP_LA2;
      default: return OP_LA3;
    endcase
  endfunction

  function automatic logic [3:0] ld_op(input logic [1:0] idx);
    case (idx)
      2'd0:    return OP_LD0;
      2'd1:    return OP_LD1;
      2'd2:    return OP_LD2;
      default: return OP_LD3;
    endcase
  endfunction

  // Lowest set lane at or above start: {found, lane}.
  function automatic logic [2:0] next_lane(input logic [3:0] mask, input logic [2:0] start);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(start) && mask[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_ctl1_seq_timeout.sv
// Loadable down-counter; expire_o marks the final cycle of the wait window.
// Revision: 1.0
`default_nettype none

module ddr_ctl1_seq_timeout #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= CNT_W'(TIMEOUT);
    end else if (dec_i && count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expire_o = dec_i && (count_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/ddr_ctl1_sequencer.sv
// Serialises 32-bit page requests into the DdrCtl1 {opcode,imm8} stream and reports completion.
// Optional address cache: define DDR_CTL1_SEQ_ADDR_CACHE_EN. Revision: 1.0
`default_nettype none

module ddr_ctl1_sequencer
  import ddr_ctl1_sequencer_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_data_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_data_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_en_o,
  input  logic [31:0]       ctl_page_i,
  input  logic              ctl_ready_i
);

  state_t            state_q, state_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              write_q, write_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_en_q, inst_en_d;
  logic [2:0]        w_lane;
  logic [3:0]        w_mask_acc, w_mask_cur;
  logic              w_expire;

  ddr_ctl1_seq_timeout #(
    .TIMEOUT (BUSY_TIMEOUT)
  ) u_timeout (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .load_i   (state_q == ST_ISSUE),
    .dec_i    (state_q == ST_WAIT_BUSY),
    .expire_o (w_expire)
  );

`ifdef DDR_CTL1_SEQ_ADDR_CACHE_EN
  logic [31:0] cache_q;
  logic        cache_vld_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
    end else if (state_q == ST_ISSUE) begin
      cache_q     <= addr_q;
      cache_vld_q <= 1'b1;
    end
  end

  always_comb begin
    w_mask_acc = '0;
    w_mask_cur = '0;
    for (int i = 0; i < 4; i++) begin
      w_mask_acc[i] = !cache_vld_q || (req_addr_i[8*i +: 8] != cache_q[8*i +: 8]);
      w_mask_cur[i] = !cache_vld_q || (addr_q[8*i +: 8] != cache_q[8*i +: 8]);
    end
  end
`else
  assign w_mask_acc = 4'hF;
  assign w_mask_cur = 4'hF;
`endif

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    addr_d     = addr_q;
    data_d     = data_q;
    write_d    = write_q;
    rsp_data_d = rsp_data_q;
    w_lane     = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          addr_d  = req_addr_i;
          data_d  = req_data_i;
          write_d = req_write_i;
          w_lane  = next_lane(w_mask_acc, 3'd0);
          if (w_lane[2]) begin
            state_d = ST_ADDR;
            byte_d  = w_lane[1:0];
          end else begin
            byte_d  = 2'd0;
            state_d = req_write_i ? ST_DATA : ST_ISSUE;
          end
        end
      end
      ST_ADDR: begin
        w_lane = next_lane(w_mask_cur, {1'b0, byte_q} + 3'd1);
        if (w_lane[2]) begin
          byte_d = w_lane[1:0];
        end else begin
          byte_d  = 2'd0;
          state_d = write_q ? ST_DATA : ST_ISSUE;
        end
      end
      ST_DATA: begin
        byte_d = byte_q + 2'd1;
        if (byte_q == 2'd3) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!ctl_ready_i) begin
          state_d = ST_WAIT_DONE;
        end else if (w_expire) begin
          state_d    = ST_RESP;
          rsp_data_d = write_q ? 32'h0 : ctl_page_i;
        end
      end
      ST_WAIT_DONE: begin
        if (ctl_ready_i) begin
          state_d    = ST_RESP;
          rsp_data_d = write_q ? 32'h0 : ctl_page_i;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q after the edge.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE) && ctl_ready_i;
    rsp_valid_d = (state_d == ST_RESP);
    inst_en_d   = 1'b1;
    case (state_d)
      ST_ADDR:  inst_d = {la_op(byte_d), addr_d[{byte_d, 3'b000} +: 8]};
      ST_DATA:  inst_d = {ld_op(byte_d), data_d[{byte_d, 3'b000} +: 8]};
      ST_ISSUE: inst_d = {(write_d ? OP_WRP : OP_RDP), 8'h00};
      default: begin
        inst_d    = {OP_NOP, 8'h00};
        inst_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      inst_q      <= {OP_NOP, 8'h00};
      inst_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      write_q     <= write_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      inst_q      <= inst_d;
      inst_en_q   <= inst_en_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign inst_o      = inst_q;
  assign inst_en_o   = inst_en_q;

endmodule

`default_nettype wire

// File: tb/tb_ddr_ctl1_sequencer.sv
// Directed self-checking bench for ddr_ctl1_sequencer (cache scenario selected by DDR_CTL1_SEQ_ADDR_CACHE_EN).
// Revision: 1.0
`default_nettype none

module tb_ddr_ctl1_sequencer;

  localparam int BT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [11:0] inst;
  logic        inst_en;
  logic [31:0] ctl_page = '0;
  logic        ctl_ready = 1'b1;

  int checks = 0;
  int fails  = 0;

  ddr_ctl1_sequencer #(.BUSY_TIMEOUT(BT)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .inst_o      (inst),
    .inst_en_o   (inst_en),
    .ctl_page_i  (ctl_page),
    .ctl_ready_i (ctl_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    ctl_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Waits for req_ready, presents one request for a single cycle; returns in the first cycle after accept.
  task automatic send_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL accept_wait: req_ready=%b required 1", req_ready);
    end
    req_write = w;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Controller goes busy for two cycles, then returns to ready with the given page; returns in RESP.
  task automatic ctl_complete(input logic [31:0] page);
    ctl_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    ctl_page  = page;
    ctl_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctl_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (inst !== 12'h000 || inst_en !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: inst=%h en=%b rdy=%b rv=%b rd=%h required 000 0 0 0 00000000",
               inst, inst_en, req_ready, rsp_valid, rsp_data);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_write();
    logic [11:0] exp [9];
    exp = '{12'h112, 12'h23F, 12'h32B, 12'h400, 12'h5AA, 12'h6BB, 12'h7CC, 12'h8DD, 12'hA00};
    do_reset();
    send_req(1'b1, 32'h002B3F12, 32'hDDCCBBAA);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (inst_en !== 1'b1 || inst !== exp[i]) begin
        fails++;
        $display("FAIL write_stream[%0d]: en=%b inst=%h required 1 %h", i, inst_en, inst, exp[i]);
      end
      @(negedge clock);
    end
    checks++;
    if (inst_en !== 1'b0) begin
      fails++;
      $display("FAIL write_wait_quiet: inst_en=%b required 0", inst_en);
    end
    ctl_complete(32'h12345678);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL write_resp: rv=%b rd=%h rdy=%b required 1 00000000 0", rsp_valid, rsp_data, req_ready);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || inst_en !== 1'b0) begin
      fails++;
      $display("FAIL write_back_idle: rv=%b rdy=%b en=%b required 0 1 0", rsp_valid, req_ready, inst_en);
    end
  endtask

  task automatic test_read();
    logic [11:0] exp [5];
    exp = '{12'h112, 12'h23F, 12'h32B, 12'h400, 12'h900};
    do_reset();
    send_req(1'b0, 32'h002B3F12, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_en !== 1'b1 || inst !== exp[i]) begin
        fails++;
        $display("FAIL read_stream[%0d]: en=%b inst=%h required 1 %h", i, inst_en, inst, exp[i]);
      end
      @(negedge clock);
    end
    ctl_complete(32'hEFEFEFEF);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hEFEFEFEF) begin
      fails++;
      $display("FAIL read_resp: rv=%b rd=%h required 1 efefefef", rsp_valid, rsp_data);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL read_resp_pulse: rv=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_ctl_not_ready();
    int bad = 0;
    do_reset();
    ctl_ready = 1'b0;
    @(negedge clock);
    req_write = 1'b0;
    req_addr  = 32'h002B3F12;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (req_ready !== 1'b0 || inst_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL holdoff: cycles_with_ready_or_inst=%0d required 0", bad);
    end
    ctl_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || inst_en !== 1'b0) begin
      fails++;
      $display("FAIL holdoff_release: rdy=%b en=%b required 1 0", req_ready, inst_en);
    end
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (inst_en !== 1'b1 || inst !== 12'h112 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL holdoff_accept: en=%b inst=%h rdy=%b required 1 112 0", inst_en, inst, req_ready);
    end
  endtask

  task automatic test_busy_timeout();
    int early = 0;
    do_reset();
    send_req(1'b1, 32'h01020304, 32'h0A0B0C0D);
    for (int i = 0; i < 8; i++) @(negedge clock);
    checks++;
    if (inst_en !== 1'b1 || inst !== 12'hA00) begin
      fails++;
      $display("FAIL timeout_issue: en=%b inst=%h required 1 a00", inst_en, inst);
    end
    for (int k = 1; k <= BT; k++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      fails++;
      $display("FAIL timeout_early: early_pulses=%0d required 0", early);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      fails++;
      $display("FAIL timeout_resp: rv=%b rd=%h required 1 00000000", rsp_valid, rsp_data);
    end
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_idle: rv=%b rdy=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_data();
    int pulses = 0;
    logic [11:0] exp [9];
    exp = '{12'h112, 12'h23F, 12'h32B, 12'h400, 12'h544, 12'h633, 12'h722, 12'h811, 12'hA00};
    do_reset();
    send_req(1'b1, 32'h002B3F12, 32'h11223344);
    for (int i = 0; i < 5; i++) @(negedge clock);
    checks++;
    if (inst !== 12'h633) begin
      fails++;
      $display("FAIL abort_at_ld1: inst=%h required 633", inst);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (inst_en !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_outputs: en=%b rdy=%b rv=%b required 0 0 0", inst_en, req_ready, rsp_valid);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL abort_no_resp: rsp_pulses=%0d required 0", pulses);
    end
    send_req(1'b1, 32'h002B3F12, 32'hDDCCBBAA);
    exp[4] = 12'h5AA; exp[5] = 12'h6BB; exp[6] = 12'h7CC; exp[7] = 12'h8DD;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (inst_en !== 1'b1 || inst !== exp[i]) begin
        fails++;
        $display("FAIL abort_resend[%0d]: en=%b inst=%h required 1 %h", i, inst_en, inst, exp[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_repeat_reads();
    logic [11:0] full [5];
    full = '{12'h112, 12'h23F, 12'h32B, 12'h400, 12'h900};
    do_reset();
    send_req(1'b0, 32'h002B3F12, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_en !== 1'b1 || inst !== full[i]) begin
        fails++;
        $display("FAIL rep_first[%0d]: en=%b inst=%h required 1 %h", i, inst_en, inst, full[i]);
      end
      @(negedge clock);
    end
    ctl_complete(32'h01010101);
    send_req(1'b0, 32'h002B3F12, 32'h0);
`ifdef DDR_CTL1_SEQ_ADDR_CACHE_EN
    checks++;
    if (inst_en !== 1'b1 || inst !== 12'h900) begin
      fails++;
      $display("FAIL cache_hit_issue: en=%b inst=%h required 1 900", inst_en, inst);
    end
    @(negedge clock);
    checks++;
    if (inst_en !== 1'b0) begin
      fails++;
      $display("FAIL cache_hit_quiet: en=%b required 0", inst_en);
    end
    ctl_complete(32'h02020202);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h02020202) begin
      fails++;
      $display("FAIL cache_hit_resp: rv=%b rd=%h required 1 02020202", rsp_valid, rsp_data);
    end
    send_req(1'b0, 32'h002B3F13, 32'h0);
    checks++;
    if (inst_en !== 1'b1 || inst !== 12'h113) begin
      fails++;
      $display("FAIL cache_partial_la0: en=%b inst=%h required 1 113", inst_en, inst);
    end
    @(negedge clock);
    checks++;
    if (inst_en !== 1'b1 || inst !== 12'h900) begin
      fails++;
      $display("FAIL cache_partial_issue: en=%b inst=%h required 1 900", inst_en, inst);
    end
    @(negedge clock);
`else
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_en !== 1'b1 || inst !== full[i]) begin
        fails++;
        $display("FAIL rep_second[%0d]: en=%b inst=%h required 1 %h", i, inst_en, inst, full[i]);
      end
      @(negedge clock);
    end
`endif
    ctl_complete(32'h03030303);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h03030303) begin
      fails++;
      $display("FAIL rep_last_resp: rv=%b rd=%h required 1 03030303", rsp_valid, rsp_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ctl_not_ready();
    test_busy_timeout();
    test_reset_mid_data();
    test_repeat_reads();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
